// File: rtl/systolic_feeder.sv
// Operand staging and diagonal skew between the TPU sequencer and the systolic MAC array.
// Buffers one A row and one B column per load cycle, then streams skewed edges for 3N-2 beats.
module systolic_feeder #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_en,
    input  logic [AW-1:0]   load_addr,
    input  logic [N*DW-1:0] a_row_in,
    input  logic [N*DW-1:0] b_col_in,
    input  logic            start_stream,
    output logic [N*DW-1:0] a_out,
    output logic [N*DW-1:0] b_out,
    output logic            valid_out,
    output logic            busy,
    output logic            stream_done
);

    localparam int TW = $clog2(3 * N - 1);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [TW-1:0] T_END = TW'(3 * N - 2);

    typedef enum logic {IDLE, STREAM} state_t;

    // Handshake: start_stream is a level sampled at clk; in IDLE with load_en low it is
    // accepted and beat 0 appears on the next cycle with valid_out high for 3N-2 cycles.
    state_t        state, state_nxt;
    logic [TW-1:0] t, t_nxt, t_sel;
    logic          emit, done_nxt, load_ok;
    logic [N*DW-1:0] a_beat, b_beat;

    // a_buf[r][k] = A[r][k], b_buf[k][c] = B[k][c]
    logic [DW-1:0] a_buf [N][N];
    logic [DW-1:0] b_buf [N][N];

    assign load_ok = (state == IDLE) && load_en && (int'(load_addr) < N);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            t     <= '0;
        end else begin
            state <= state_nxt;
            t     <= t_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        t_nxt     = t;
        t_sel     = t;
        emit      = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start_stream && !load_en) begin
                    state_nxt = STREAM;
                    t_nxt     = TW'(1);
                    t_sel     = '0;
                    emit      = 1'b1;
                end
            end
            STREAM: begin
                if (t == T_END) begin
                    state_nxt = IDLE;
                    t_nxt     = '0;
                    done_nxt  = 1'b1;
                end else begin
                    t_nxt = t + TW'(1);
                    emit  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Lane i carries the element whose diagonal index t-i lands inside the matrix.
    always_comb begin
        int tt;
        a_beat = '0;
        b_beat = '0;
        tt     = int'(t_sel);
        for (int i = 0; i < N; i++) begin
            if (tt >= i && tt - i < N) begin
                a_beat[i*DW +: DW] = a_buf[i][IW'(tt - i)];
                b_beat[i*DW +: DW] = b_buf[IW'(tt - i)][i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    a_buf[r][c] <= '0;
                    b_buf[r][c] <= '0;
                end
            end
        end else if (load_ok) begin
            for (int i = 0; i < N; i++) begin
                a_buf[load_addr[IW-1:0]][i] <= a_row_in[i*DW +: DW];
                b_buf[i][load_addr[IW-1:0]] <= b_col_in[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_out       <= '0;
            b_out       <= '0;
            valid_out   <= 1'b0;
            busy        <= 1'b0;
            stream_done <= 1'b0;
        end else begin
            a_out       <= emit ? a_beat : '0;
            b_out       <= emit ? b_beat : '0;
            valid_out   <= emit;
            busy        <= emit;
            stream_done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: reference matrices in the bench, skewed beats
// predicted into a queue and compared as the DUT emits them.
module tb_systolic_feeder;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int BEATS = 3 * N - 2;
    localparam int W     = 2 * N * DW;

    logic            clk = 1'b0;
    logic            rst;
    logic            load_en;
    logic [AW-1:0]   load_addr;
    logic [N*DW-1:0] a_row_in;
    logic [N*DW-1:0] b_col_in;
    logic            start_stream;
    logic [N*DW-1:0] a_out;
    logic [N*DW-1:0] b_out;
    logic            valid_out;
    logic            busy;
    logic            stream_done;

    systolic_feeder #(.N(N), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
        .a_row_in(a_row_in), .b_col_in(b_col_in), .start_stream(start_stream),
        .a_out(a_out), .b_out(b_out), .valid_out(valid_out), .busy(busy),
        .stream_done(stream_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0]    exp_q[$];
    logic [DW-1:0]   ma [N][N];
    logic [DW-1:0]   mb [N][N];
    logic [N*DW-1:0] got_a [BEATS];
    logic [N*DW-1:0] got_b [BEATS];

    function automatic logic [W-1:0] model_beat(input int t);
        logic [N*DW-1:0] ea, eb;
        ea = '0;
        eb = '0;
        for (int i = 0; i < N; i++) begin
            if (t - i >= 0 && t - i < N) begin
                ea[i*DW +: DW] = ma[i][t-i];
                eb[i*DW +: DW] = mb[t-i][i];
            end
        end
        return {ea, eb};
    endfunction

    task automatic model_clear();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ma[r][c] = '0;
                mb[r][c] = '0;
            end
    endtask

    task automatic drive_load(input int addr, input logic [N*DW-1:0] a, input logic [N*DW-1:0] b);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = AW'(addr);
        a_row_in  = a;
        b_col_in  = b;
        @(negedge clk);
        load_en = 1'b0;
        if (addr < N)
            for (int i = 0; i < N; i++) begin
                ma[addr][i] = a[i*DW +: DW];
                mb[i][addr] = b[i*DW +: DW];
            end
    endtask

    // reps > 1 keeps start_stream high through each stream_done cycle; dirty drives
    // all-ones loads throughout the stream, which must not reach the buffers.
    task automatic stream_check(input string nm, input int reps, input bit dirty);
        logic [W-1:0] e;
        for (int r = 0; r < reps; r++)
            for (int b = 0; b < BEATS; b++) exp_q.push_back(model_beat(b));
        @(negedge clk);
        start_stream = 1'b1;
        for (int r = 0; r < reps; r++) begin
            for (int b = 0; b < BEATS; b++) begin
                @(negedge clk);
                if (b == 0 && r == reps - 1) start_stream = 1'b0;
                load_en = dirty && (b < BEATS - 1);
                if (dirty) begin
                    load_addr = AW'(b % N);
                    a_row_in  = '1;
                    b_col_in  = '1;
                end
                n_tests++;
                if (valid_out !== 1'b1 || busy !== 1'b1 || stream_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s_ctl rep%0d beat%0d: valid=%b busy=%b done=%b, required 1 1 0",
                             nm, r, b, valid_out, busy, stream_done);
                end
                if (valid_out === 1'b1 && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    got_a[b] = a_out;
                    got_b[b] = b_out;
                    n_tests++;
                    if ({a_out, b_out} !== e) begin
                        n_fail++;
                        $display("FAIL %s_data rep%0d beat%0d: a=%h b=%h, required a=%h b=%h",
                                 nm, r, b, a_out, b_out, e[W-1 -: N*DW], e[N*DW-1:0]);
                    end
                end
            end
            @(negedge clk);
            n_tests++;
            if (stream_done !== 1'b1 || valid_out !== 1'b0 || busy !== 1'b0 ||
                a_out !== '0 || b_out !== '0) begin
                n_fail++;
                $display("FAIL %s_done rep%0d: done=%b valid=%b busy=%b a=%h b=%h, required 1 0 0 0 0",
                         nm, r, stream_done, valid_out, busy, a_out, b_out);
            end
        end
        @(negedge clk);
        n_tests++;
        if (stream_done !== 1'b0 || valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_after: done=%b valid=%b, required 0 0", nm, stream_done, valid_out);
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d beats left, required 0", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3 rst = 1'b1;
        #1;
        n_tests++;
        if (a_out !== '0 || b_out !== '0 || valid_out !== 1'b0 || busy !== 1'b0 || stream_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: a=%h b=%h v=%b busy=%b done=%b, required all 0",
                     a_out, b_out, valid_out, busy, stream_done);
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        stream_check("reset_zero_stream", 1, 1'b0);
    endtask

    task automatic test_load_stream();
        for (int r = 0; r < N; r++) begin
            logic [N*DW-1:0] a, b;
            for (int k = 0; k < N; k++) begin
                a[k*DW +: DW] = DW'(10 * r + k + 1);
                b[k*DW +: DW] = DW'(20 + 4 * k + r);
            end
            drive_load(r, a, b);
        end
        stream_check("load_stream", 1, 1'b0);
        n_tests++;
        if (got_a[0] !== 32'h0000_0001 || got_b[0] !== 32'h0000_0014) begin
            n_fail++;
            $display("FAIL beat0_const: a=%h b=%h, required 00000001 00000014", got_a[0], got_b[0]);
        end
        n_tests++;
        if (got_a[3][7:0] !== 8'd4 || got_a[3][31:24] !== 8'd31 ||
            got_b[3][7:0] !== 8'd32 || got_b[3][31:24] !== 8'd23) begin
            n_fail++;
            $display("FAIL beat3_const: a=%h b=%h, required a lane0=4 lane3=31, b lane0=32 lane3=23",
                     got_a[3], got_b[3]);
        end
        n_tests++;
        if (got_a[6] !== 32'h2200_0000 || got_b[6] !== 32'h2300_0000) begin
            n_fail++;
            $display("FAIL beat6_const: a=%h b=%h, required 22000000 23000000", got_a[6], got_b[6]);
        end
        n_tests++;
        if (got_a[9] !== '0 || got_b[9] !== '0) begin
            n_fail++;
            $display("FAIL beat9_const: a=%h b=%h, required 0 0", got_a[9], got_b[9]);
        end
    endtask

    task automatic test_collision();
        logic [N*DW-1:0] a, b;
        a = {$urandom_range(1, 255) & 8'hFF, 8'h5A, 8'hA5, 8'h3C};
        b = {8'h11, 8'h22, $urandom_range(1, 255) & 8'hFF, 8'h44};
        @(negedge clk);
        load_en = 1'b1; load_addr = AW'(2); a_row_in = a; b_col_in = b; start_stream = 1'b1;
        @(negedge clk);
        load_en = 1'b0; start_stream = 1'b0;
        for (int i = 0; i < N; i++) begin
            ma[2][i] = a[i*DW +: DW];
            mb[i][2] = b[i*DW +: DW];
        end
        for (int c = 0; c < 2; c++) begin
            n_tests++;
            if (valid_out !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL collision_nostart cyc%0d: valid=%b busy=%b, required 0 0", c, valid_out, busy);
            end
            @(negedge clk);
        end
        stream_check("collision_load_applied", 1, 1'b0);
        stream_check("load_during_stream", 1, 1'b1);
        stream_check("rerun_after_dirty", 1, 1'b0);
    endtask

    task automatic test_out_of_range();
        drive_load(5, {N{8'h77}}, {N{8'h99}});
        stream_check("out_of_range", 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        stream_check("back_to_back", 2, 1'b0);
    endtask

    task automatic test_reset_mid();
        for (int b = 0; b < BEATS; b++) exp_q.push_back(model_beat(b));
        @(negedge clk);
        start_stream = 1'b1;
        for (int b = 0; b <= 4; b++) begin
            @(negedge clk);
            start_stream = 1'b0;
            n_tests++;
            if ({a_out, b_out} !== exp_q.pop_front() || valid_out !== 1'b1) begin
                n_fail++;
                $display("FAIL midreset_pre beat%0d: a=%h b=%h valid=%b", b, a_out, b_out, valid_out);
            end
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (a_out !== '0 || b_out !== '0 || valid_out !== 1'b0 || busy !== 1'b0 || stream_done !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: a=%h b=%h v=%b busy=%b done=%b, required all 0",
                     a_out, b_out, valid_out, busy, stream_done);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        model_clear();
        for (int c = 0; c < BEATS; c++) begin
            @(negedge clk);
            n_tests++;
            if (stream_done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_nodone cyc%0d: done=%b busy=%b, required 0 0", c, stream_done, busy);
            end
        end
        stream_check("midreset_cleared", 1, 1'b0);
    endtask

    initial begin
        rst = 1'b0; load_en = 1'b0; load_addr = '0; a_row_in = '0; b_col_in = '0;
        start_stream = 1'b0;
        model_clear();
        test_reset();
        test_load_stream();
        test_collision();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
